apb_reg_bridge: RTL and testbench

APB_REG_BRIDGE -- requirements
Module: apb_reg_bridge

---
 rtl/apb_reg_bridge_if.sv | 25 ++
 rtl/apb_reg_bridge.sv | 117 +++++++++++
 tb/tb_apb_reg_bridge.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_reg_bridge_if.sv
// APB slave-side bus bundle for apb_reg_bridge.
// The master modport is the requester; the slave modport is the bridge.
interface apb_reg_bridge_if #(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 8
);
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [ADDRWIDTH-1:0] paddr;
  logic [DATAWIDTH-1:0] pwdata;
  logic [DATAWIDTH-1:0] prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_reg_bridge.sv
// APB-to-register-bank bridge: one-cycle write/read strobes toward a simple
// register bank, range-checked offsets and a saturating error-completion counter.
module apb_reg_bridge #(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 8,
  parameter int NUMREGS   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  apb_reg_bridge_if.slave      apb,
  output logic [ADDRWIDTH-1:0] addr,
  output logic                 wen,
  output logic [DATAWIDTH-1:0] wr_data,
  output logic                 ren,
  input  logic [DATAWIDTH-1:0] rd_data,
  output logic [7:0]           err_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    RWAIT = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [31:0] NUMREGS_W = 32'(NUMREGS);

  state_t               state_r;
  state_t               next_state_s;
  logic                 setup_s;
  logic                 access_s;
  logic                 out_of_range_s;
  logic                 err_done_s;
  logic [DATAWIDTH-1:0] prdata_r;
  logic                 pready_r;
  logic                 pslverr_r;
  logic [ADDRWIDTH-1:0] addr_r;
  logic                 wen_r;
  logic [DATAWIDTH-1:0] wr_data_r;
  logic                 ren_r;
  logic [7:0]           err_cnt_r;

  assign setup_s        = apb.psel & ~apb.penable;
  assign access_s       = apb.psel & apb.penable;
  // Widen before comparing so NUMREGS == 2**ADDRWIDTH does not wrap.
  assign out_of_range_s = (32'(apb.paddr) >= NUMREGS_W);
  assign err_done_s     = (state_r == ERR) && access_s;

  // Next-state decode; dropping psel anywhere past IDLE abandons the transfer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (setup_s) begin
          if (out_of_range_s) begin
            next_state_s = ERR;
          end else if (apb.pwrite) begin
            next_state_s = WR;
          end else begin
            next_state_s = RD;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      WR:        next_state_s = apb.psel ? DONE : IDLE;
      RD:        next_state_s = apb.psel ? RWAIT : IDLE;
      RWAIT:     next_state_s = apb.psel ? DONE : IDLE;
      DONE, ERR: next_state_s = (access_s || !apb.psel) ? IDLE : state_r;
      default:   next_state_s = IDLE;
    endcase
  end

  // State plus every output, registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      prdata_r  <= '0;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      addr_r    <= '0;
      wen_r     <= 1'b0;
      wr_data_r <= '0;
      ren_r     <= 1'b0;
      err_cnt_r <= 8'd0;
    end else begin
      state_r   <= next_state_s;
      wen_r     <= (next_state_s == WR);
      ren_r     <= (next_state_s == RD);
      pready_r  <= (next_state_s == DONE) || (next_state_s == ERR);
      pslverr_r <= (next_state_s == ERR);
      // Only the setup cycle is captured; later bus changes are ignored.
      if ((state_r == IDLE) && setup_s) begin
        addr_r    <= apb.paddr;
        wr_data_r <= apb.pwdata;
      end
      if (state_r == RWAIT) begin
        prdata_r <= rd_data;
      end
      if (err_done_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

  assign apb.prdata  = prdata_r;
  assign apb.pready  = pready_r;
  assign apb.pslverr = pslverr_r;
  assign addr        = addr_r;
  assign wen         = wen_r;
  assign wr_data     = wr_data_r;
  assign ren         = ren_r;
  assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Directed self-checking bench for apb_reg_bridge with a small register bank
// attached; expected values are hand-computed constants.
module tb_apb_reg_bridge;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic          wen;
  logic          ren;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic [7:0]    err_cnt;
  logic [DW-1:0] mem [NR];
  int            checks = 0;
  int            errors = 0;

  apb_reg_bridge_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) apb ();

  apb_reg_bridge #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .NUMREGS(NR)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .apb     (apb),
    .addr    (addr),
    .wen     (wen),
    .wr_data (wr_data),
    .ren     (ren),
    .rd_data (rd_data),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  // Register bank: write on wen, read data valid the cycle after ren.
  always @(posedge clk) begin
    if (wen) mem[addr[1:0]] <= wr_data;
    if (ren) rd_data <= mem[addr[1:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic bus(input logic s, input logic e, input logic w,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    apb.psel    = s;
    apb.penable = e;
    apb.pwrite  = w;
    apb.paddr   = a;
    apb.pwdata  = d;
  endtask

  initial begin
    int exp_cnt;
    rst_n = 1'b0;
    bus(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    step();
    step();
    sample();
    check("rst_prdata",  32'(apb.prdata),  32'h00);
    check("rst_pready",  32'(apb.pready),  32'h0);
    check("rst_pslverr", 32'(apb.pslverr), 32'h0);
    check("rst_wen",     32'(wen),         32'h0);
    check("rst_ren",     32'(ren),         32'h0);
    check("rst_addr",    32'(addr),        32'h0);
    check("rst_wr_data", 32'(wr_data),     32'h00);
    check("rst_err_cnt", 32'(err_cnt),     32'h00);
    rst_n = 1'b1;
    step();

    // Write 0xA5 to offset 2; bus changes after setup must be ignored.
    bus(1'b1, 1'b0, 1'b1, 4'd2, 8'hA5);
    sample();
    check("wr_t0_pready", 32'(apb.pready), 32'h0);
    step();
    bus(1'b1, 1'b1, 1'b1, 4'd3, 8'h5A);
    sample();
    check("wr_t1_wen",     32'(wen),        32'h1);
    check("wr_t1_addr",    32'(addr),       32'h2);
    check("wr_t1_wr_data", 32'(wr_data),    32'hA5);
    check("wr_t1_ren",     32'(ren),        32'h0);
    check("wr_t1_pready",  32'(apb.pready), 32'h0);
    step();
    sample();
    check("wr_t2_pready",  32'(apb.pready),  32'h1);
    check("wr_t2_pslverr", 32'(apb.pslverr), 32'h0);
    check("wr_t2_wen",     32'(wen),         32'h0);
    check("wr_t2_addr",    32'(addr),        32'h2);
    step();
    bus(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    sample();
    check("wr_t3_pready", 32'(apb.pready), 32'h0);

    // Read offset 2 back.
    step();
    bus(1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
    step();
    bus(1'b1, 1'b1, 1'b0, 4'd2, 8'h00);
    sample();
    check("rd_t1_ren",    32'(ren),        32'h1);
    check("rd_t1_wen",    32'(wen),        32'h0);
    check("rd_t1_addr",   32'(addr),       32'h2);
    check("rd_t1_pready", 32'(apb.pready), 32'h0);
    step();
    sample();
    check("rd_t2_ren",    32'(ren),        32'h0);
    check("rd_t2_pready", 32'(apb.pready), 32'h0);
    step();
    sample();
    check("rd_t3_pready",  32'(apb.pready),  32'h1);
    check("rd_t3_pslverr", 32'(apb.pslverr), 32'h0);
    check("rd_t3_prdata",  32'(apb.prdata),  32'hA5);
    step();
    bus(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    sample();
    check("rd_hold_prdata", 32'(apb.prdata), 32'hA5);

    // Out-of-range write: error in T1, no strobe, prdata untouched.
    step();
    bus(1'b1, 1'b0, 1'b1, 4'd7, 8'hFF);
    step();
    bus(1'b1, 1'b1, 1'b1, 4'd7, 8'hFF);
    sample();
    check("err_t1_pready",  32'(apb.pready),  32'h1);
    check("err_t1_pslverr", 32'(apb.pslverr), 32'h1);
    check("err_t1_wen",     32'(wen),         32'h0);
    check("err_t1_cnt",     32'(err_cnt),     32'h00);
    step();
    bus(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    sample();
    check("err_t2_cnt",    32'(err_cnt),     32'h01);
    check("err_t2_pready", 32'(apb.pready),  32'h0);
    check("err_t2_wen",    32'(wen),         32'h0);
    check("err_prdata",    32'(apb.prdata),  32'hA5);

    // psel dropped after setup: strobe already issued, then back to IDLE.
    step();
    bus(1'b1, 1'b0, 1'b1, 4'd1, 8'h33);
    step();
    bus(1'b0, 1'b0, 1'b1, 4'd1, 8'h33);
    sample();
    check("abort_t1_wen",     32'(wen),     32'h1);
    check("abort_t1_wr_data", 32'(wr_data), 32'h33);
    step();
    sample();
    check("abort_t2_wen",    32'(wen),        32'h0);
    check("abort_t2_pready", 32'(apb.pready), 32'h0);

    // Back-to-back: write offset 0 = 0x11, then read it from the next IDLE.
    step();
    bus(1'b1, 1'b0, 1'b1, 4'd0, 8'h11);
    step();
    bus(1'b1, 1'b1, 1'b1, 4'd0, 8'h11);
    step();
    sample();
    check("b2b_wr_pready", 32'(apb.pready), 32'h1);
    step();
    bus(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    sample();
    check("b2b_idle_pready", 32'(apb.pready), 32'h0);
    step();
    bus(1'b1, 1'b1, 1'b0, 4'd0, 8'h00);
    sample();
    check("b2b_rd_ren",  32'(ren),  32'h1);
    check("b2b_rd_addr", 32'(addr), 32'h0);
    step();
    step();
    sample();
    check("b2b_rd_pready", 32'(apb.pready), 32'h1);
    check("b2b_rd_prdata", 32'(apb.prdata), 32'h11);
    step();
    bus(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

    // Reset asserted while in RWAIT.
    step();
    bus(1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
    step();
    bus(1'b1, 1'b1, 1'b0, 4'd2, 8'h00);
    step();
    rst_n = 1'b0;
    step();
    sample();
    check("rwrst_prdata",  32'(apb.prdata),  32'h00);
    check("rwrst_pready",  32'(apb.pready),  32'h0);
    check("rwrst_pslverr", 32'(apb.pslverr), 32'h0);
    check("rwrst_ren",     32'(ren),         32'h0);
    check("rwrst_addr",    32'(addr),        32'h0);
    check("rwrst_err_cnt", 32'(err_cnt),     32'h00);
    rst_n = 1'b1;
    bus(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    step();

    // 300 error completions; counter saturates at 255.
    for (int n = 1; n <= 300; n++) begin
      bus(1'b1, 1'b0, n[0], 4'hF, 8'h00);
      step();
      bus(1'b1, 1'b1, n[0], 4'hF, 8'h00);
      step();
      sample();
      exp_cnt = (n > 255) ? 255 : n;
      if (n == 1 || n == 254 || n == 255 || n == 256 || n == 300) begin
        check($sformatf("sat_cnt_%0d", n), 32'(err_cnt), 32'(exp_cnt));
      end
    end
    bus(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    step();
    sample();
    check("sat_wen", 32'(wen), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
